// File: rtl/owl_frame_rx.sv
// owl_frame_rx: length-prefixed frame receiver driving an external CRC-16 engine,
// buffering the payload and releasing it downstream only after the residue check passes.
module owl_frame_rx #(
    parameter int   MAX_LEN = 16,
    parameter int   TIMEOUT = 255,
    parameter logic CRC_TYP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       crc_en,
    output logic       crc_clr,
    output logic       crc_typ,
    output logic       crc_calcu,
    output logic [7:0] crc_din,
    input  logic       crc_rlt,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       frm_done,
    output logic       frm_ok,
    output logic [1:0] frm_err
);
    localparam int          AW      = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_B   = 8'(MAX_LEN);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LEN_OK, PAYLOAD, CRC_LO, CRC_HI, CHECK, DRAIN} state_t;

    state_t      state;
    logic [7:0]  len;
    logic [7:0]  idx;
    logic [7:0]  rd;
    logic [15:0] tcnt;
    logic [7:0]  mem [MAX_LEN];
    logic        take;

    assign take    = in_valid && in_ready;
    assign crc_typ = CRC_TYP;

    always_ff @(posedge clk)
        if (state == PAYLOAD && take) mem[idx[AW-1:0]] <= in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            crc_en    <= 1'b0;
            crc_clr   <= 1'b0;
            crc_calcu <= 1'b0;
            crc_din   <= 8'h00;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            frm_done  <= 1'b0;
            frm_ok    <= 1'b0;
            frm_err   <= 2'd0;
            len       <= 8'h00;
            idx       <= 8'h00;
            rd        <= 8'h00;
            tcnt      <= 16'h0000;
        end else begin
            crc_calcu <= 1'b0;
            frm_done  <= 1'b0;
            crc_clr   <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    crc_en   <= 1'b0;
                    if (take) begin
                        if (in_data == 8'h00 || in_data > MAX_B) begin
                            frm_done <= 1'b1;
                            frm_ok   <= 1'b0;
                            frm_err  <= 2'd1;
                        end else begin
                            len    <= in_data;
                            idx    <= 8'h00;
                            tcnt   <= 16'h0000;
                            crc_en <= 1'b1;
                            state  <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD, CRC_LO, CRC_HI: begin
                    // acceptance is checked first so a byte arriving on the expiry cycle still counts
                    if (take) begin
                        in_ready  <= 1'b0;
                        crc_calcu <= 1'b1;
                        crc_din   <= in_data;
                        tcnt      <= 16'h0000;
                        if (state == PAYLOAD) begin
                            idx <= idx + 8'd1;
                            if (idx + 8'd1 == len) state <= CRC_LO;
                        end else begin
                            state <= state == CRC_LO ? CRC_HI : CHECK;
                        end
                    end else if (tcnt == TO_LAST) begin
                        frm_done <= 1'b1;
                        frm_ok   <= 1'b0;
                        frm_err  <= 2'd3;
                        crc_clr  <= 1'b1;
                        crc_en   <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        in_ready <= 1'b1;
                        tcnt     <= tcnt + 16'd1;
                    end
                end
                CHECK: begin
                    // first CHECK cycle carries the CRC_HI strobe; the residue is valid one cycle later
                    if (!crc_calcu) begin
                        frm_done <= 1'b1;
                        if (crc_rlt) begin
                            frm_ok    <= 1'b1;
                            frm_err   <= 2'd0;
                            out_valid <= 1'b1;
                            out_data  <= mem[0];
                            rd        <= 8'd1;
                            state     <= DRAIN;
                        end else begin
                            frm_ok   <= 1'b0;
                            frm_err  <= 2'd2;
                            crc_clr  <= 1'b1;
                            crc_en   <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd == len) begin
                            out_valid <= 1'b0;
                            crc_clr   <= 1'b1;
                            crc_en    <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_data <= mem[rd[AW-1:0]];
                            rd       <= rd + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
